// File: rtl/fft_feeder_if.sv
// Sample-stream and FFT-core signal bundle for fft_feeder.
//   s_valid/s_ready/s_re/s_im/s_last : incoming complex sample stream
//   fft_next/fft_in_re/fft_in_im     : frame launch pulse and packed frame data
//   frame_short                      : launched frame was zero-padded
//   fft_next_out                     : core reports one frame result done
// slave  = the feeder's view, master = the producer/core side.
interface fft_feeder_if #(
    parameter int N = 8,
    parameter int W = 32
);
    logic           s_valid;
    logic           s_ready;
    logic [W-1:0]   s_re;
    logic [W-1:0]   s_im;
    logic           s_last;
    logic           fft_next;
    logic [N*W-1:0] fft_in_re;
    logic [N*W-1:0] fft_in_im;
    logic           fft_next_out;
    logic           frame_short;

    modport slave (
        input  s_valid, s_re, s_im, s_last, fft_next_out,
        output s_ready, fft_next, fft_in_re, fft_in_im, frame_short
    );

    modport master (
        output s_valid, s_re, s_im, s_last, fft_next_out,
        input  s_ready, fft_next, fft_in_re, fft_in_im, frame_short
    );
endinterface

// File: rtl/fft_feeder.sv
// Collects N complex samples into a frame, zero-pads frames closed early by
// s_last, and launches each frame to an FFT core with a one-cycle fft_next
// pulse, honouring a minimum pulse spacing and a cap on unanswered frames.
//   clk, reset     : clock, asynchronous active-low reset
//   bus (slave)    : sample stream in, frame data / launch pulse out
//   inflight       : launched frames not yet answered by fft_next_out
//   err_underflow  : sticky, fft_next_out seen with nothing in flight
module fft_feeder #(
    parameter int N            = 8,
    parameter int W            = 32,
    parameter int MIN_GAP      = 4,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    fft_feeder_if.slave                       bus,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight,
    output logic                              err_underflow
);
    localparam int IDX_W = $clog2(N);
    localparam int IF_W  = $clog2(MAX_INFLIGHT + 1);
    localparam int GAP_W = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;

    typedef enum logic [1:0] {COLLECT, PENDING, LAUNCH} state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [GAP_W-1:0] gap_cnt;
    logic             short_q;
    logic [W-1:0]     col_re [N];
    logic [W-1:0]     col_im [N];

    logic accept, close, early, dec, can_launch;

    // The launch decision is made one cycle ahead because fft_next is
    // registered: gap_cnt<=1 means it reads zero in the launch cycle, and
    // inflight is judged after this cycle's fft_next_out is applied.
    always_comb begin
        accept     = bus.s_valid && bus.s_ready;
        close      = accept && (bus.s_last || idx == IDX_W'(N - 1));
        early      = close && (idx != IDX_W'(N - 1));
        dec        = bus.fft_next_out && (inflight != '0);
        can_launch = (gap_cnt <= GAP_W'(1)) &&
                     ((inflight - IF_W'(dec)) < IF_W'(MAX_INFLIGHT));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= COLLECT;
            idx             <= '0;
            gap_cnt         <= '0;
            short_q         <= 1'b0;
            bus.s_ready     <= 1'b0;
            bus.fft_next    <= 1'b0;
            bus.frame_short <= 1'b0;
            bus.fft_in_re   <= '0;
            bus.fft_in_im   <= '0;
            for (int k = 0; k < N; k++) begin
                col_re[k] <= '0;
                col_im[k] <= '0;
            end
        end else begin
            bus.fft_next    <= 1'b0;
            bus.frame_short <= 1'b0;
            if (bus.fft_next)
                gap_cnt <= GAP_W'(MIN_GAP - 1);
            else if (gap_cnt != '0)
                gap_cnt <= gap_cnt - GAP_W'(1);

            case (state)
                COLLECT: begin
                    bus.s_ready <= 1'b1;
                    if (accept) begin
                        idx <= idx + IDX_W'(1);
                        for (int k = 0; k < N; k++) begin
                            if (IDX_W'(k) == idx) begin
                                col_re[k] <= bus.s_re;
                                col_im[k] <= bus.s_im;
                            end else if (early && k > int'(idx)) begin
                                col_re[k] <= '0;
                                col_im[k] <= '0;
                            end
                        end
                        if (close) begin
                            short_q     <= early;
                            bus.s_ready <= 1'b0;
                            if (can_launch) begin
                                state           <= LAUNCH;
                                bus.fft_next    <= 1'b1;
                                bus.frame_short <= early;
                            end else begin
                                state <= PENDING;
                            end
                        end
                    end
                end
                PENDING: begin
                    if (can_launch) begin
                        state           <= LAUNCH;
                        bus.fft_next    <= 1'b1;
                        bus.frame_short <= short_q;
                    end
                end
                LAUNCH: begin
                    for (int k = 0; k < N; k++) begin
                        bus.fft_in_re[k*W +: W] <= col_re[k];
                        bus.fft_in_im[k*W +: W] <= col_im[k];
                    end
                    idx         <= '0;
                    state       <= COLLECT;
                    bus.s_ready <= 1'b1;
                end
                default: state <= COLLECT;
            endcase
        end
    end

    // A simultaneous launch and completion leave the count unchanged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inflight      <= '0;
            err_underflow <= 1'b0;
        end else begin
            if (bus.fft_next_out && inflight == '0)
                err_underflow <= 1'b1;
            if (bus.fft_next && !bus.fft_next_out)
                inflight <= inflight + IF_W'(1);
            else if (!bus.fft_next && dec)
                inflight <= inflight - IF_W'(1);
        end
    end
endmodule

// File: tb/tb_fft_feeder.sv
module tb_fft_feeder;
    localparam int N       = 8;
    localparam int W       = 32;
    localparam int MIN_GAP = 4;
    localparam int MAX_INF = 4;
    localparam int IF_W    = $clog2(MAX_INF + 1);

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic [IF_W-1:0] inflight;
    logic            err;

    fft_feeder_if #(.N(N), .W(W)) bus ();

    fft_feeder #(.N(N), .W(W), .MIN_GAP(MIN_GAP), .MAX_INFLIGHT(MAX_INF)) dut (
        .clk(clk), .reset(rst_n), .bus(bus.slave),
        .inflight(inflight), .err_underflow(err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [N*W-1:0] got, input logic [N*W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Frame-level view: a queue of collected samples, a closed flag, the
    // time of the last launch and an outstanding-frame count.
    logic         m_ready, m_next, m_short, m_err;
    int           m_inf;
    int           last_launch;
    bit           closed, cl_short;
    logic [W-1:0] q_re[$], q_im[$];
    logic [W-1:0] f_re[N], f_im[N];
    logic [W-1:0] m_out_re[N], m_out_im[N];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ready = 0; m_next = 0; m_short = 0; m_err = 0; m_inf = 0;
            last_launch = -1000; closed = 0; cl_short = 0;
            q_re.delete(); q_im.delete();
            for (int k = 0; k < N; k++) begin
                f_re[k] = '0; f_im[k] = '0; m_out_re[k] = '0; m_out_im[k] = '0;
            end
        end else begin
            cyc++;
            if (bus.fft_next_out && m_inf == 0) m_err = 1;
            if (m_next && !bus.fft_next_out) m_inf++;
            else if (!m_next && bus.fft_next_out && m_inf > 0) m_inf--;
            if (m_next) begin
                m_out_re = f_re;
                m_out_im = f_im;
            end
            if (m_ready && bus.s_valid) begin
                q_re.push_back(bus.s_re);
                q_im.push_back(bus.s_im);
                if (bus.s_last || q_re.size() == N) begin
                    cl_short = (q_re.size() < N);
                    while (q_re.size() < N) begin
                        q_re.push_back('0);
                        q_im.push_back('0);
                    end
                    closed = 1;
                end
            end
            m_next = 0; m_short = 0;
            if (closed && (cyc - last_launch) >= MIN_GAP && m_inf < MAX_INF) begin
                m_next = 1; m_short = cl_short; last_launch = cyc; closed = 0;
                for (int k = 0; k < N; k++) begin
                    f_re[k] = q_re[k]; f_im[k] = q_im[k];
                end
                q_re.delete(); q_im.delete();
            end
            m_ready = !closed && !m_next;
        end
    end

    logic [N*W-1:0] er, ei;
    always @(negedge clk) begin
        for (int k = 0; k < N; k++) begin
            er[k*W +: W] = m_out_re[k];
            ei[k*W +: W] = m_out_im[k];
        end
        chk("s_ready",       bus.s_ready,     m_ready);
        chk("fft_next",      bus.fft_next,    m_next);
        chk("frame_short",   bus.frame_short, m_short);
        chk("inflight",      inflight,        m_inf);
        chk("err_underflow", err,             m_err);
        chk("fft_in_re",     bus.fft_in_re,   er);
        chk("fft_in_im",     bus.fft_in_im,   ei);
    end

    time pulse_t[$];
    always @(posedge clk) if (bus.fft_next) pulse_t.push_back($time);

    // ---------------- stimulus helpers ----------------
    function automatic logic [W-1:0] sre(input int k);
        return bus.fft_in_re[k*W +: W];
    endfunction
    function automatic logic [W-1:0] sim(input int k);
        return bus.fft_in_im[k*W +: W];
    endfunction

    task automatic send(input logic [W-1:0] re, input logic [W-1:0] im, input logic last);
        int t = 0;
        bus.s_valid = 1'b1; bus.s_re = re; bus.s_im = im; bus.s_last = last;
        while (!bus.s_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("send_ready_wait", bus.s_ready, 1'b1);
        @(negedge clk);
        bus.s_valid = 1'b0; bus.s_last = 1'b0;
    endtask

    task automatic pulse_done();
        bus.fft_next_out = 1'b1;
        @(negedge clk);
        bus.fft_next_out = 1'b0;
    endtask

    logic [W-1:0] va, vb;
    int d, np;

    initial begin
        bus.s_valid = 0; bus.s_re = '0; bus.s_im = '0; bus.s_last = 0; bus.fft_next_out = 0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_ready", bus.s_ready, 1'b0);
        chk("reset_out",   bus.fft_in_re, '0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", bus.s_ready, 1'b1);

        // full frame, (k+1, -(k+1))
        for (int k = 0; k < N; k++) begin
            va = W'(k + 1); vb = W'(-(k + 1));
            send(va, vb, 1'b0);
        end
        chk("t1_next_T+1",  bus.fft_next, 1'b1);
        chk("t1_short",     bus.frame_short, 1'b0);
        @(negedge clk);
        chk("t1_slot0_re",  sre(0), 32'd1);
        chk("t1_slot3_re",  sre(3), 32'd4);
        chk("t1_slot7_im",  sim(7), 32'hFFFF_FFF8);
        chk("t1_ready_T+2", bus.s_ready, 1'b1);
        pulse_done();

        // short frame of 3
        send(32'h11, 32'h21, 1'b0);
        send(32'h12, 32'h22, 1'b0);
        send(32'h13, 32'h23, 1'b1);
        chk("t2_next",  bus.fft_next, 1'b1);
        chk("t2_short", bus.frame_short, 1'b1);
        @(negedge clk);
        chk("t2_slot2_re", sre(2), 32'h13);
        for (int k = 3; k < N; k++) begin
            chk("t2_pad_re", sre(k), '0);
            chk("t2_pad_im", sim(k), '0);
        end

        // full frame then a 2-sample frame, back to back
        for (int k = 0; k < N; k++) begin
            va = W'(32'hA0 + k);
            send(va, va, 1'b0);
        end
        send(32'hB0, 32'hC0, 1'b0);
        send(32'hB1, 32'hC1, 1'b1);
        repeat (3) @(negedge clk);
        d = int'((pulse_t[pulse_t.size()-1] - pulse_t[pulse_t.size()-2]) / 10);
        chk("t3_gap_cycles", d, 4);
        chk("t3_b_slot0", sre(0), 32'hB0);
        chk("t3_b_slot2", sre(2), '0);

        // drain, then fill to MAX_INFLIGHT
        repeat (3) pulse_done();
        chk("t4_drained", inflight, 0);
        for (int i = 0; i < 4; i++) begin
            va = W'(32'h300 + i);
            send(va, va, 1'b1);
        end
        repeat (6) @(negedge clk);
        chk("t4_inflight_max", inflight, 4);
        np = pulse_t.size();
        send(32'h400, 32'h400, 1'b1);
        repeat (8) @(negedge clk);
        chk("t4_stalled_no_pulse", pulse_t.size(), np);
        chk("t4_stalled_ready",    bus.s_ready, 1'b0);
        pulse_done();
        chk("t4_launch_after_done", bus.fft_next, 1'b1);
        @(negedge clk);
        chk("t4_inflight_back", inflight, 4);
        pulse_done();
        repeat (6) @(negedge clk);
        send(32'h500, 32'h500, 1'b1);
        chk("t4_launch_sim", bus.fft_next, 1'b1);
        pulse_done();
        chk("t4_sim_unchanged", inflight, 3);

        // underflow
        repeat (3) pulse_done();
        chk("t5_zero", inflight, 0);
        pulse_done();
        chk("t5_err",      err, 1'b1);
        chk("t5_inflight", inflight, 0);

        // reset mid-frame
        np = pulse_t.size();
        for (int k = 0; k < 5; k++) begin
            va = W'(32'h55 + k);
            send(va, va, 1'b0);
        end
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            va = W'(100 + k);
            send(va, va, 1'b0);
        end
        chk("t6_next", bus.fft_next, 1'b1);
        @(negedge clk);
        chk("t6_one_pulse", pulse_t.size(), np + 1);
        chk("t6_slot0",     sre(0), 32'd100);
        chk("t6_slot4",     sre(4), 32'd104);
        chk("t6_err_clr",   err, 1'b0);
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end
endmodule
